// File: rtl/pipe_pkg.sv
// Shared EX->MEM pipeline definitions: writeback-select codes, default widths,
// the canonical stage payload layout and the skid-buffer state encoding.
package pipe_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int WSEL_W_DEF = 2;

  localparam logic [1:0] WSEL_PASS = 2'd0;
  localparam logic [1:0] WSEL_RAM  = 2'd1;
  localparam logic [1:0] WSEL_ALU  = 2'd2;
  localparam logic [1:0] WSEL_RSV  = 2'd3;

  // Field order matches the concatenation used by ex_mem_skid_stage.
  typedef struct packed {
    logic [XLEN_DEF-1:0]   pc;
    logic [WSEL_W_DEF-1:0] rf_wsel;
    logic                  rf_we;
    logic                  ram_we;
    logic [XLEN_DEF-1:0]   wdin;
    logic [XLEN_DEF-1:0]   alu_c;
    logic                  alu_f;
    logic [REG_AW_DEF-1:0] wr;
    logic [XLEN_DEF-1:0]   wd;
  } ex_mem_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic int ex_mem_width(input int xlen, input int reg_aw, input int wsel_w);
    return 4 * xlen + wsel_w + 3 + reg_aw;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main register drives the output, skid catches
// the one beat accepted while the consumer stalls.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q & ~flush;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: if (in_fire) begin
        state_d = SKID_ONE;
        main_d  = in_data;
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = SKID_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: if (out_fire) begin
        state_d = SKID_ONE;
        main_d  = skid_q;
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Flush leaves payload stale; it is don't-care once out_valid drops.
    if (flush) begin
      state_d = SKID_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != SKID_FULL);
  end

  always_comb begin
    out_valid = (state_q != SKID_EMPTY);
    occupancy = state_q;
    in_ready  = in_ready_q;
    out_data  = main_q;
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM stage with valid/ready handshake over a 2-entry skid buffer; the
// writeback data is resolved at capture and the head entry feeds forwarding.
module ex_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int WSEL_W = WSEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_wdin,
  input  logic [XLEN-1:0]   in_alu_c,
  input  logic [XLEN-1:0]   in_wd,
  input  logic [WSEL_W-1:0] in_rf_wsel,
  input  logic              in_rf_we,
  input  logic              in_ram_we,
  input  logic              in_alu_f,
  input  logic [REG_AW-1:0] in_wr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_wdin,
  output logic [XLEN-1:0]   out_alu_c,
  output logic [XLEN-1:0]   out_wd,
  output logic [WSEL_W-1:0] out_rf_wsel,
  output logic              out_rf_we,
  output logic              out_ram_we,
  output logic              out_alu_f,
  output logic [REG_AW-1:0] out_wr,
  output logic              fwd_we,
  output logic [REG_AW-1:0] fwd_wr,
  output logic [XLEN-1:0]   fwd_wd,
  output logic [1:0]        occupancy
);

  localparam int PW = ex_mem_width(XLEN, REG_AW, WSEL_W);

  logic [XLEN-1:0] wd_sel;
  logic [PW-1:0]   in_data, out_data;

  assign wd_sel  = (in_rf_wsel == WSEL_W'(WSEL_ALU)) ? in_alu_c : in_wd;
  assign in_data = {in_pc, in_rf_wsel, in_rf_we, in_ram_we, in_wdin,
                    in_alu_c, in_alu_f, in_wr, wd_sel};

  pipe_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  assign {out_pc, out_rf_wsel, out_rf_we, out_ram_we, out_wdin,
          out_alu_c, out_alu_f, out_wr, out_wd} = out_data;

  // Load results are not available yet, so RAM-sourced writes never forward.
  assign fwd_we = out_valid & out_rf_we & (out_rf_wsel != WSEL_W'(WSEL_RAM));
  assign fwd_wr = out_wr;
  assign fwd_wd = out_wd;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Scoreboard bench for ex_mem_skid_stage: directed scenarios plus a long
// random valid/ready/flush run against a queue of expected head entries.
module tb_ex_mem_skid_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  wsel;
    logic        rf_we;
    logic        ram_we;
    logic [31:0] wdin;
    logic [31:0] alu_c;
    logic        alu_f;
    logic [4:0]  wr;
    logic [31:0] wd;
  } pay_t;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_wdin, in_alu_c, in_wd;
  logic [1:0]  in_rf_wsel;
  logic        in_rf_we, in_ram_we, in_alu_f;
  logic [4:0]  in_wr;
  logic [31:0] out_pc, out_wdin, out_alu_c, out_wd, fwd_wd;
  logic [1:0]  out_rf_wsel, occupancy;
  logic        out_rf_we, out_ram_we, out_alu_f, fwd_we;
  logic [4:0]  out_wr, fwd_wr;

  int n_chk = 0;
  int n_fail = 0;
  pay_t exp_q[$];

  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_wdin(in_wdin), .in_alu_c(in_alu_c), .in_wd(in_wd),
    .in_rf_wsel(in_rf_wsel), .in_rf_we(in_rf_we), .in_ram_we(in_ram_we),
    .in_alu_f(in_alu_f), .in_wr(in_wr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_wdin(out_wdin), .out_alu_c(out_alu_c), .out_wd(out_wd),
    .out_rf_wsel(out_rf_wsel), .out_rf_we(out_rf_we), .out_ram_we(out_ram_we),
    .out_alu_f(out_alu_f), .out_wr(out_wr), .fwd_we(fwd_we), .fwd_wr(fwd_wr),
    .fwd_wd(fwd_wd), .occupancy(occupancy)
  );

  function automatic pay_t cur_pay();
    pay_t p;
    p.pc = in_pc; p.wsel = in_rf_wsel; p.rf_we = in_rf_we; p.ram_we = in_ram_we;
    p.wdin = in_wdin; p.alu_c = in_alu_c; p.alu_f = in_alu_f; p.wr = in_wr;
    p.wd = (in_rf_wsel == 2'd2) ? in_alu_c : in_wd;
    return p;
  endfunction

  function automatic pay_t out_pay();
    return {out_pc, out_rf_wsel, out_rf_we, out_ram_we, out_wdin,
            out_alu_c, out_alu_f, out_wr, out_wd};
  endfunction

  // Advance one clock and update the reference queue from the pre-edge inputs.
  task automatic tick();
    int   sz = exp_q.size();
    bit   of = (sz > 0) && out_ready;
    bit   inf = in_valid && (sz < 2) && !flush;
    bit   rst = !rst_n;
    bit   fl = flush;
    pay_t p = cur_pay();
    @(posedge clk);
    if (rst || fl) exp_q.delete();
    else begin
      if (of) void'(exp_q.pop_front());
      if (inf) exp_q.push_back(p);
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [1:0] wsel,
                       input bit we, input logic [31:0] alu_c, input logic [31:0] wd);
    in_valid = v; in_pc = pc; in_rf_wsel = wsel; in_rf_we = we; in_alu_c = alu_c;
    in_wd = wd; in_wdin = pc ^ 32'h5A5A_0000; in_ram_we = wsel[0]; in_alu_f = pc[2];
    in_wr = pc[6:2];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b1; out_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFF0, 2'd2, 1'b1, 32'h1, 32'h2);
    tick(); tick();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_chk++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    n_chk++; if (fwd_we !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_we got %b want 0", fwd_we); end
    n_chk++; if (out_pay() !== '0 || fwd_wr !== 5'd0 || fwd_wd !== 32'd0) begin
      n_fail++; $display("FAIL reset_payload got %h want 0", out_pay()); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pcs[i], 2'd0, 1'b0, 32'h0, 32'h0);
      tick();
      n_chk++; if (out_valid !== 1'b1 || out_pc !== pcs[i]) begin
        n_fail++; $display("FAIL stream_pc[%0d] got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, pcs[i]); end
      n_chk++; if (occupancy > 2'd1 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%b want occ<=1 rdy=1", i, occupancy, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_wsel();
    out_ready = 1'b1;
    drive(1'b1, 32'h40, 2'd2, 1'b1, 32'h1234, 32'hDEAD);
    tick();
    n_chk++; if (out_wd !== 32'h1234 || fwd_wd !== 32'h1234) begin
      n_fail++; $display("FAIL wsel_alu got %h/%h want 1234", out_wd, fwd_wd); end
    n_chk++; if (fwd_we !== 1'b1 || fwd_wr !== 5'h10) begin
      n_fail++; $display("FAIL wsel_alu_fwd got we=%b wr=%h want we=1 wr=10", fwd_we, fwd_wr); end
    drive(1'b1, 32'h44, 2'd0, 1'b1, 32'h1234, 32'hDEAD);
    tick();
    n_chk++; if (out_wd !== 32'hDEAD || fwd_we !== 1'b1) begin
      n_fail++; $display("FAIL wsel_pass got wd=%h we=%b want DEAD/1", out_wd, fwd_we); end
    drive(1'b1, 32'h48, 2'd1, 1'b1, 32'h1234, 32'hDEAD);
    tick();
    n_chk++; if (fwd_we !== 1'b0 || out_valid !== 1'b1 || out_wd !== 32'hDEAD) begin
      n_fail++; $display("FAIL wsel_ram got fwd_we=%b v=%b wd=%h want 0/1/DEAD", fwd_we, out_valid, out_wd); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 2'd2, 1'b1, 32'h10, 32'h0);
    tick();
    n_chk++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_one got occ=%0d rdy=%b want 1/1", occupancy, in_ready); end
    drive(1'b1, 32'h14, 2'd2, 1'b1, 32'h14, 32'h0);
    tick();
    n_chk++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h10) begin
      n_fail++; $display("FAIL bp_full got occ=%0d rdy=%b pc=%h want 2/0/10", occupancy, in_ready, out_pc); end
    drive(1'b1, 32'h18, 2'd2, 1'b1, 32'h18, 32'h0);
    tick();
    n_chk++; if (occupancy !== 2'd2 || out_pc !== 32'h10) begin
      n_fail++; $display("FAIL bp_hold got occ=%0d pc=%h want 2/10", occupancy, out_pc); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h14 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL bp_second got v=%b pc=%h rdy=%b occ=%0d want 1/14/1/1", out_valid, out_pc, in_ready, occupancy); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_nodup got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h30, 2'd0, 1'b1, 32'h0, 32'h30); tick();
    drive(1'b1, 32'h34, 2'd0, 1'b1, 32'h0, 32'h34); tick();
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h20, 2'd0, 1'b1, 32'h0, 32'h20);
    tick();
    n_chk++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || fwd_we !== 1'b0) begin
      n_fail++; $display("FAIL flush_full got v=%b occ=%0d rdy=%b fwd=%b want 0/0/1/0", out_valid, occupancy, in_ready, fwd_we); end
    flush = 1'b0; in_valid = 1'b0;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got v=%b pc=%h want 0", out_valid, out_pc); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    drive(1'b1, 32'h50, 2'd2, 1'b1, 32'h50, 32'h0); tick();
    drive(1'b1, 32'h54, 2'd2, 1'b1, 32'h54, 32'h0); tick();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    n_chk++; if (occupancy !== 2'd2 || out_pc !== 32'h50) begin
      n_fail++; $display("FAIL async_pulse got occ=%0d pc=%h want 2/50", occupancy, out_pc); end
    tick();
    n_chk++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_hold got occ=%0d rdy=%b want 2/0", occupancy, in_ready); end
    rst_n = 1'b0; flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h58, 2'd2, 1'b1, 32'h58, 32'h0);
    tick();
    n_chk++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || fwd_we !== 1'b0 ||
                 out_pay() !== '0 || fwd_wd !== 32'd0 || fwd_wr !== 5'd0) begin
      n_fail++; $display("FAIL reset_full got v=%b occ=%0d rdy=%b pay=%h want all 0, rdy=1", out_valid, occupancy, in_ready, out_pay()); end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_random();
    int errs = 0;
    pay_t e;
    for (int c = 0; c < 10000; c++) begin
      flush = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
            1'($urandom), $urandom, $urandom);
      tick();
      n_chk++;
      if (out_valid !== (exp_q.size() != 0) || occupancy !== 2'(exp_q.size()) ||
          in_ready !== (exp_q.size() != 2)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_ctl cyc %0d got v=%b occ=%0d rdy=%b want occ=%0d", c, out_valid, occupancy, in_ready, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        n_chk++;
        if (out_pay() !== e || fwd_wr !== e.wr || fwd_wd !== e.wd ||
            fwd_we !== (e.rf_we && e.wsel != 2'd1)) begin
          n_fail++; errs++;
          if (errs < 10) $display("FAIL rand_head cyc %0d got %h fwd=%b want %h", c, out_pay(), fwd_we, e);
        end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_stream();
    test_wsel();
    test_backpressure();
    test_flush();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_stage.md
# ex_mem_skid_stage

Parametrised EX→MEM pipeline stage that replaces the fixed free-running EX/MEM register. It adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and configurable data and register-address widths. It resolves the writeback-data select at capture time and exports a forwarding port from the head entry. It sits between the EX stage (ALU, branch flag) and the MEM stage (data RAM, writeback mux).

## Interface
- XLEN, 32: width of pc, wdin, alu_c, wd
- REG_AW, 5: register-file address width
- WSEL_W, 2: width of rf_wsel
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on the clk rising edge
- flush  in  1  synchronous kill of all held entries and of this cycle's input
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage can accept; registered
- in_pc, in_wdin, in_alu_c, in_wd  in  XLEN each  EX payload
- in_rf_wsel  in  WSEL_W  writeback select
- in_rf_we, in_ram_we, in_alu_f  in  1 each  control bits
- in_wr  in  REG_AW  destination register
- out_valid  out  1  head entry valid (replaces have_inst)
- out_ready  in  1  MEM accepts head entry
- out_pc, out_wdin, out_alu_c, out_wd, out_rf_wsel, out_rf_we, out_ram_we, out_alu_f, out_wr  out  same widths  head payload
- fwd_we  out  1  head holds an ALU/pass result writing a register
- fwd_wr  out  REG_AW  forwarding destination
- fwd_wd  out  XLEN  forwarding data
- occupancy  out  2  entries held (0..2)

## Operation
- in_fire = in_valid & in_ready & ~flush; out_fire = out_valid & out_ready.
- Writeback select encoding: WSEL_PASS=0, WSEL_RAM=1, WSEL_ALU=2, WSEL_RSV=3.
- Captured wd = in_alu_c when in_rf_wsel==WSEL_ALU, else in_wd. The selection is done at capture; both main and skid store the resolved value.
- States: EMPTY (occupancy 0), ONE (main valid), FULL (main+skid valid).
- EMPTY: in_fire → ONE, main<=in.
- ONE: in_fire&out_fire → ONE, main<=in. in_fire&~out_ready → FULL, skid<=in. out_fire only → EMPTY. Otherwise hold.
- FULL: in_ready=0. out_fire → ONE, main<=skid. Otherwise hold, main stable.
- flush (rst_n high) → EMPTY regardless of state, out_fire, or in_valid. Incoming data is dropped. Payload registers keep stale values; they are don't-care while out_valid=0.
- fwd_we = out_valid & out_rf_we & (out_rf_wsel != WSEL_RAM). fwd_wr=out_wr, fwd_wd=out_wd. Load data is never forwarded from this stage.
- out_* payload must stay stable while out_valid & ~out_ready.

## Timing
- Reset (rst_n low at a clk edge) → state EMPTY; out_valid=0, in_ready=1, occupancy=0, fwd_we=0.
- Reset also zeroes all out_* payload, fwd_wr and fwd_wd, plus the skid payload.
- Reset overrides flush and every handshake. Reset mid-FULL discards both entries.
- Latency: in_fire at edge N → out_valid with payload visible after edge N. Throughput is 1 per cycle when out_ready is held high.
- in_ready = ~FULL, registered. It falls the cycle after the FULL transition and rises the cycle after FULL→ONE.
- occupancy and out_valid update on the same edge as the state.

## Structure
- Shared package pipe_pkg: WSEL_PASS/RAM/ALU/RSV constants, default XLEN and REG_AW, and a packed struct ex_mem_t (pc, rf_wsel, rf_we, ram_we, wdin, alu_c, alu_f, wr, wd) parametrised by the package widths.
- One sub-module: pipe_skid_buf. It is a generic 2-entry skid buffer over a W-bit payload with in/out valid/ready, flush, synchronous active-low reset, and occupancy.
- ex_mem_skid_stage instantiates pipe_skid_buf, does the wd pre-select and pack/unpack, and derives the fwd_* outputs.

## Test plan
- Reset then stream, out_ready=1: 4 back-to-back fires, pc 0x0,0x4,0x8,0xC → out_pc same sequence at edges N+1..N+4, occupancy never >1, in_ready stays 1.
- wsel select: in_rf_wsel=2, alu_c=0x1234, wd=0xDEAD → out_wd=0x1234. Same with wsel=0 → 0xDEAD. Same with wsel=1, rf_we=1 → fwd_we=0.
- Backpressure: ONE with pc 0x10 and out_ready=0, then fire pc 0x14 → FULL, in_ready=0 next cycle, out_pc holds 0x10. Raise out_ready → 0x10 then 0x14 delivered, no loss or duplication.
- Flush in FULL with in_valid=1 (pc 0x20) → next cycle out_valid=0, occupancy=0, in_ready=1. pc 0x20 never appears.
- rst_n low for one edge while FULL, with flush and in_valid high → all outputs 0, in_ready=1. An asynchronous rst_n pulse between edges has no effect.
- Random valid/ready/flush for 10k cycles vs. a scoreboard queue: order preserved, payload stable under stall, fwd_* consistent with the head entry.
